// File: rtl/miniRV_ctrl_pkg.sv
// rtl/miniRV_ctrl_pkg.sv - shared encodings for the multicycle controller
//
// Purpose: FSM state encoding, writeback-source codes, trap-cause codes and a
// one-hot check used by the controller and its wait timer.
// Ports: none (package).

package miniRV_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_TRAP    = 3'd6
  } state_t;

  // Writeback source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_IMM = 2'd2;
  localparam logic [1:0] WB_PC4 = 2'd3;

  // Trap cause
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  localparam int WAIT_W = 8;

  // True when exactly one bit of the decoded flag vector is set.
  function automatic logic is_onehot9(input logic [8:0] f);
    return (f != 9'd0) && ((f & (f - 9'd1)) == 9'd0);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - memory wait counter with timeout detection
//
// Purpose: counts cycles spent waiting on a memory ready handshake and flags
// when the count has reached LIMIT.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   clear   in   restart the count from zero (wins over count)
//   count   in   one more wait cycle elapsed
//   expired out  count has reached LIMIT

module wait_timer #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [WIDTH-1:0] cnt_q;

  assign expired = (cnt_q == WIDTH'(LIMIT));

  // Holds at LIMIT once reached; the controller traps on that cycle anyway.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count && !expired) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle CPU control FSM
//
// Purpose: sequences FETCH/DECODE/EXECUTE/MEM/WB for a small RISC-V subset,
// with memory-wait timeouts, a sticky trap state and a retired counter.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   run                         permits a new fetch (sampled in IDLE and at completion)
//   add..jalr, illegal          one-hot decoded instruction flags
//   imem_ready, dmem_ready      memory handshake completions
//   imem_req, ir_load           instruction fetch request / IR capture
//   pc_enable, pc_sel           PC update strobe / source (0 pc+4, 1 ALU)
//   alu_b_sel                   ALU operand B (0 rs2, 1 immediate)
//   dmem_req, dmem_we, dmem_byte data-memory request qualifiers
//   reg_write, wb_sel           register-file write strobe / source
//   state                       current state for debug
//   trap, trap_cause            sticky fault and its cause
//   retired                     completed-instruction count (wraps)

module multicycle_controller
  import miniRV_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             add,
  input  logic             addi,
  input  logic             lui,
  input  logic             lw,
  input  logic             lbu,
  input  logic             sw,
  input  logic             sb,
  input  logic             jalr,
  input  logic             illegal,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_enable,
  output logic             pc_sel,
  output logic             alu_b_sel,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             dmem_byte,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_n;
  logic [1:0]       cause_q, cause_n;
  logic             imem_req_q, alu_b_sel_q, dmem_req_q, dmem_we_q, dmem_byte_q;
  logic             wb_strobe_q, pc_sel_q, trap_q;
  logic [1:0]       wb_sel_q, wb_src;
  logic [CNT_W-1:0] retired_q;

  logic is_load, is_store, uses_imm, decode_ok;
  logic store_done, retire;
  logic wt_clear, wt_count, wt_expired;

  assign is_load   = lw | lbu;
  assign is_store  = sw | sb;
  assign uses_imm  = addi | is_load | is_store | jalr;
  assign decode_ok = is_onehot9({illegal, jalr, sb, sw, lbu, lw, lui, addi, add}) && !illegal;

  // Stores finish in MEM itself: the PC update and retirement happen on the
  // ready cycle rather than in a WB state.
  assign store_done = (state_q == ST_MEM) && dmem_ready && is_store;
  assign retire     = (state_q == ST_WB) || store_done;

  always_comb begin
    wb_src = WB_ALU;
    if (is_load)   wb_src = WB_MEM;
    else if (lui)  wb_src = WB_IMM;
    else if (jalr) wb_src = WB_PC4;
  end

  // Ready in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_n = state_q;
    cause_n = cause_q;
    case (state_q)
      ST_IDLE:    if (run) state_n = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          state_n = ST_DECODE;
        end else if (wt_expired) begin
          state_n = ST_TRAP;
          cause_n = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if (decode_ok) begin
          state_n = ST_EXECUTE;
        end else begin
          state_n = ST_TRAP;
          cause_n = CAUSE_ILLEGAL;
        end
      end
      ST_EXECUTE: state_n = (is_load || is_store) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (dmem_ready) begin
          if (is_load)  state_n = ST_WB;
          else          state_n = run ? ST_FETCH : ST_IDLE;
        end else if (wt_expired) begin
          state_n = ST_TRAP;
          cause_n = CAUSE_DMEM_TO;
        end
      end
      ST_WB:      state_n = run ? ST_FETCH : ST_IDLE;
      ST_TRAP:    state_n = ST_TRAP;
      default:    state_n = ST_IDLE;
    endcase
  end

  // The timer restarts whenever a waiting state is freshly entered.
  assign wt_clear = (state_n != state_q) && ((state_n == ST_FETCH) || (state_n == ST_MEM));
  assign wt_count = ((state_q == ST_FETCH) && !imem_ready) ||
                    ((state_q == ST_MEM)   && !dmem_ready);

  wait_timer #(
    .WIDTH (WAIT_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wt_clear),
    .count   (wt_count),
    .expired (wt_expired)
  );

  // State-derived strobes are registered from the next state so they line up
  // with state_q; only ir_load and the store pc_enable react to ready directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_NONE;
      trap_q      <= 1'b0;
      imem_req_q  <= 1'b0;
      alu_b_sel_q <= 1'b0;
      dmem_req_q  <= 1'b0;
      dmem_we_q   <= 1'b0;
      dmem_byte_q <= 1'b0;
      wb_strobe_q <= 1'b0;
      wb_sel_q    <= WB_ALU;
      pc_sel_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_n;
      cause_q     <= cause_n;
      trap_q      <= (state_n == ST_TRAP);
      imem_req_q  <= (state_n == ST_FETCH);
      alu_b_sel_q <= ((state_n == ST_EXECUTE) || (state_n == ST_MEM)) && uses_imm;
      dmem_req_q  <= (state_n == ST_MEM);
      dmem_we_q   <= (state_n == ST_MEM) && is_store;
      dmem_byte_q <= (state_n == ST_MEM) && (lbu || sb);
      wb_strobe_q <= (state_n == ST_WB);
      wb_sel_q    <= (state_n == ST_WB) ? wb_src : WB_ALU;
      pc_sel_q    <= (state_n == ST_WB) && jalr;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state      = state_q;
  assign imem_req   = imem_req_q;
  assign ir_load    = (state_q == ST_FETCH) && imem_ready;
  assign pc_enable  = wb_strobe_q || store_done;
  assign pc_sel     = pc_sel_q;
  assign alu_b_sel  = alu_b_sel_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_byte  = dmem_byte_q;
  assign reg_write  = wb_strobe_q;
  assign wb_sel     = wb_sel_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller

module tb_multicycle_controller;

  localparam int ADD = 0, ADDI = 1, LUI = 2, LW = 3, LBU = 4, SW = 5, SB = 6, JALR = 7, ILL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic [8:0] flags = 9'd0;

  logic       imem_req, ir_load, pc_enable, pc_sel, alu_b_sel;
  logic       dmem_req, dmem_we, dmem_byte, reg_write, trap;
  logic [1:0] wb_sel, trap_cause;
  logic [2:0] state;
  logic [3:0] retired;

  multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run),
    .add(flags[ADD]), .addi(flags[ADDI]), .lui(flags[LUI]), .lw(flags[LW]),
    .lbu(flags[LBU]), .sw(flags[SW]), .sb(flags[SB]), .jalr(flags[JALR]),
    .illegal(flags[ILL]),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_load(ir_load), .pc_enable(pc_enable), .pc_sel(pc_sel),
    .alu_b_sel(alu_b_sel), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_byte(dmem_byte),
    .reg_write(reg_write), .wb_sel(wb_sel), .state(state), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k);
    flags    = 9'd0;
    flags[k] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; flags = 9'd0; imem_ready = 1'b0; dmem_ready = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int   ops[4];
    int   exp_b[4];
    int   exp_wb[4];
    logic rw_seen;
    ops    = '{ADD, ADDI, LUI, JALR};
    exp_b  = '{0, 1, 0, 1};
    exp_wb = '{0, 0, 2, 3};

    // Reset state
    #1 rst = 1'b0;
    tick();
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_wb_sel", wb_sel, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("idle_hold_run0", state, 0);

    // ALU-class instructions, zero-wait, run dropped mid-instruction
    for (int i = 0; i < 4; i++) begin
      set_op(ops[i]); imem_ready = 1'b1; run = 1'b1;
      tick();
      chk("fetch_state", state, 1);
      chk("fetch_imem_req", imem_req, 1);
      chk("fetch_ir_load", ir_load, 1);
      tick();
      chk("decode_state", state, 2);
      chk("decode_ir_load", ir_load, 0);
      run = 1'b0;
      tick();
      chk("exec_state", state, 3);
      chk("exec_alu_b_sel", alu_b_sel, exp_b[i]);
      chk("exec_reg_write", reg_write, 0);
      tick();
      chk("wb_state", state, 5);
      chk("wb_reg_write", reg_write, 1);
      chk("wb_pc_enable", pc_enable, 1);
      chk("wb_sel", wb_sel, exp_wb[i]);
      chk("wb_pc_sel", pc_sel, (ops[i] == JALR) ? 1 : 0);
      chk("wb_retired_before", retired, i);
      tick();
      chk("post_wb_idle", state, 0);
      chk("post_wb_retired", retired, i + 1);
      chk("post_wb_reg_write", reg_write, 0);
      chk("post_wb_pc_enable", pc_enable, 0);
      chk("post_wb_wb_sel", wb_sel, 0);
      chk("post_wb_pc_sel", pc_sel, 0);
    end

    // lw with dmem_ready delayed three cycles
    set_op(LW); dmem_ready = 1'b0; run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    chk("lw_exec_alu_b_sel", alu_b_sel, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) begin
        dmem_ready = 1'b1;
        #1;
      end
      chk("lw_mem_state", state, 4);
      chk("lw_dmem_req", dmem_req, 1);
      chk("lw_mem_alu_b_sel", alu_b_sel, 1);
      chk("lw_dmem_we", dmem_we, 0);
      chk("lw_dmem_byte", dmem_byte, 0);
      chk("lw_mem_pc_enable", pc_enable, 0);
    end
    tick();
    chk("lw_wb_state", state, 5);
    chk("lw_wb_sel", wb_sel, 1);
    chk("lw_wb_reg_write", reg_write, 1);
    chk("lw_dmem_req_off", dmem_req, 0);
    tick();
    chk("lw_retired", retired, 5);

    // lbu zero-wait
    set_op(LBU); dmem_ready = 1'b1; run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    tick();
    chk("lbu_mem_state", state, 4);
    chk("lbu_dmem_byte", dmem_byte, 1);
    chk("lbu_dmem_we", dmem_we, 0);
    tick();
    chk("lbu_wb_sel", wb_sel, 1);
    tick();
    chk("lbu_retired", retired, 6);

    // sb zero-wait: never writes the register file
    set_op(SB); dmem_ready = 1'b1; run = 1'b1; rw_seen = 1'b0;
    tick(); rw_seen |= reg_write;
    tick(); rw_seen |= reg_write;
    run = 1'b0;
    tick(); rw_seen |= reg_write;
    chk("sb_exec_alu_b_sel", alu_b_sel, 1);
    tick(); rw_seen |= reg_write;
    chk("sb_mem_state", state, 4);
    chk("sb_dmem_we", dmem_we, 1);
    chk("sb_dmem_byte", dmem_byte, 1);
    chk("sb_pc_enable", pc_enable, 1);
    chk("sb_pc_sel", pc_sel, 0);
    tick(); rw_seen |= reg_write;
    chk("sb_idle", state, 0);
    chk("sb_dmem_we_off", dmem_we, 0);
    chk("sb_retired", retired, 7);
    chk("sb_no_reg_write", rw_seen, 0);

    // sw with run held: MEM goes straight back to FETCH
    set_op(SW); run = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("sw_dmem_we", dmem_we, 1);
    chk("sw_dmem_byte", dmem_byte, 0);
    tick();
    chk("sw_to_fetch", state, 1);
    chk("sw_retired", retired, 8);
    run = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("sw2_idle", state, 0);
    chk("sw2_retired", retired, 9);

    // Flags not one-hot -> illegal trap
    flags = 9'b000000011; run = 1'b1;
    tick();
    tick();
    tick();
    chk("multi_hot_state", state, 6);
    chk("multi_hot_trap", trap, 1);
    chk("multi_hot_cause", trap_cause, 1);
    chk("multi_hot_no_retire", retired, 9);

    // Illegal instruction: trap is sticky for 100 cycles with run high
    do_reset();
    chk("post_reset_retired", retired, 0);
    chk("post_reset_trap", trap, 0);
    set_op(ILL); imem_ready = 1'b1; run = 1'b1;
    tick();
    tick();
    chk("ill_decode_trap", trap, 0);
    tick();
    chk("ill_trap", trap, 1);
    chk("ill_cause", trap_cause, 1);
    chk("ill_state", state, 6);
    repeat (100) tick();
    chk("ill_hold_state", state, 6);
    chk("ill_hold_trap", trap, 1);
    chk("ill_hold_cause", trap_cause, 1);
    chk("ill_hold_imem_req", imem_req, 0);
    chk("ill_hold_pc_enable", pc_enable, 0);
    #2 rst = 1'b0;
    #1;
    chk("ill_async_rst_state", state, 0);
    chk("ill_async_rst_trap", trap, 0);
    chk("ill_async_rst_cause", trap_cause, 0);
    tick();
    rst = 1'b1;

    // imem timeout: FETCH waits through count 0..4, then traps
    do_reset();
    set_op(ADD); imem_ready = 1'b0; run = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("imem_wait_state", state, 1);
      chk("imem_wait_req", imem_req, 1);
      tick();
    end
    chk("imem_to_state", state, 6);
    chk("imem_to_cause", trap_cause, 2);
    chk("imem_to_req_off", imem_req, 0);

    // imem_ready arriving on the expiry cycle wins
    do_reset();
    set_op(ADD); imem_ready = 1'b0; run = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    chk("imem_edge_state", state, 1);
    imem_ready = 1'b1;
    #1;
    chk("imem_edge_ir_load", ir_load, 1);
    tick();
    chk("imem_edge_decode", state, 2);
    chk("imem_edge_no_trap", trap, 0);
    run = 1'b0;
    tick();
    tick();
    tick();
    chk("imem_edge_retired", retired, 1);

    // dmem timeout on a load
    set_op(LW); dmem_ready = 1'b0; run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("dmem_wait_state", state, 4);
      tick();
    end
    chk("dmem_to_state", state, 6);
    chk("dmem_to_cause", trap_cause, 3);
    chk("dmem_to_req_off", dmem_req, 0);
    chk("dmem_to_no_retire", retired, 1);

    // Asynchronous reset in the middle of MEM
    do_reset();
    set_op(SW); imem_ready = 1'b1; dmem_ready = 1'b0; run = 1'b1;
    tick();
    tick();
    tick();
    run = 1'b0;
    tick();
    chk("rst_mem_req_before", dmem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_req_dropped", dmem_req, 0);
    chk("rst_mem_we_dropped", dmem_we, 0);
    chk("rst_mem_state", state, 0);
    chk("rst_mem_pc_enable", pc_enable, 0);
    tick();
    rst = 1'b1;

    // 4-bit retired counter wraps after 16 back-to-back adds
    set_op(ADD); imem_ready = 1'b1; run = 1'b1;
    tick();
    repeat (60) tick();
    chk("wrap_retired_15", retired, 15);
    chk("wrap_fetch16", state, 1);
    run = 1'b0;
    tick();
    tick();
    tick();
    chk("wrap_wb_state", state, 5);
    tick();
    chk("wrap_retired_0", retired, 0);
    chk("wrap_idle", state, 0);
    chk("wrap_no_trap", trap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max cycles waiting on imem_ready/dmem_ready before a timeout trap (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-003 SHALL have one clock and an asynchronous active-low reset; ports are named clk and rst, with rst low meaning reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 run  input  1  level; permits a new fetch when high.
REQ-007 add, addi, lui, lw, lbu, sw, sb, jalr, illegal  input  1 each  one-hot decoded instruction flags, valid in DECODE and later states.
REQ-008 imem_ready  input  1  instruction-memory data valid for the current imem_req.
REQ-009 dmem_ready  input  1  data-memory access complete for the current dmem_req.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 ir_load  output  1  capture the instruction register.
REQ-012 pc_enable  output  1  PC register update strobe.
REQ-013 pc_sel  output  1  selects the PC source: 0 = pc+4, 1 = ALU result.
REQ-014 alu_b_sel  output  1  selects ALU operand B: 0 = rs2, 1 = immediate.
REQ-015 dmem_req, dmem_we, dmem_byte  output  1 each  data-memory request, write, and byte-size qualifiers.
REQ-016 reg_write  output  1  register-file write strobe.
REQ-017 wb_sel  output  2  writeback source: 0 = ALU, 1 = memory, 2 = immediate, 3 = pc+4.
REQ-018 state  output  3  current state encoding, for debug.
REQ-019 trap  output  1  sticky fault indication.
REQ-020 trap_cause  output  2  fault cause: 0 = none, 1 = illegal, 2 = imem timeout, 3 = dmem timeout.
REQ-021 retired  output  CNT_W  count of completed instructions.

Function
REQ-022 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, TRAP=6; code 7 is unreachable and SHALL return to IDLE.
REQ-023 IDLE: when run=1, go to FETCH next cycle; otherwise stay in IDLE.
REQ-024 FETCH: imem_req=1 every cycle; when imem_ready=1, ir_load=1 for exactly that cycle and the next state is DECODE.
REQ-025 DECODE: lasts one cycle; if illegal=1 or the flags are not one-hot, go to TRAP with cause 1; otherwise go to EXECUTE.
REQ-026 EXECUTE: lasts one cycle; alu_b_sel=1 for addi, lw, lbu, sw, sb, jalr; loads and stores go to MEM, all other instructions go to WB.
REQ-027 MEM: dmem_req=1 with alu_b_sel held at 1; dmem_we=1 for sw/sb; dmem_byte=1 for lbu/sb.
REQ-028 MEM, on dmem_ready=1: loads go to WB; stores assert pc_enable=1 with pc_sel=0, increment retired, and go to FETCH if run=1, else IDLE.
REQ-029 WB: lasts one cycle; reg_write=1 and pc_enable=1; wb_sel = 1 for lw/lbu, 2 for lui, 3 for jalr, 0 otherwise; pc_sel=1 only for jalr; retired increments; next state is FETCH if run=1, else IDLE.
REQ-030 Every output not explicitly asserted in a state SHALL be 0, including wb_sel and pc_sel.
REQ-031 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle the ready input is low.
REQ-032 When the wait counter reaches MEM_TIMEOUT with ready still low, the FSM SHALL go to TRAP with cause 2 (FETCH) or 3 (MEM); ready arriving in that same cycle wins, and no trap is taken.
REQ-033 TRAP: trap=1, trap_cause held, all strobes 0, run ignored; only reset exits TRAP.
REQ-034 The retired counter SHALL wrap from all-ones to 0 without raising a flag.
REQ-035 Deasserting run mid-instruction SHALL NOT abort that instruction; run is sampled only at instruction completion and in IDLE.
REQ-036 Each instruction SHALL produce exactly one pc_enable pulse and at most one reg_write pulse.
REQ-037 Latency with zero-wait memory SHALL be: add/addi/lui/jalr 4 cycles FETCH->WB, loads 5 cycles, stores 4 cycles.

Reset
REQ-038 rst low SHALL asynchronously force state=IDLE, all strobes 0, wb_sel=0, trap=0, trap_cause=0, retired=0, and wait counter=0.
REQ-039 rst assertion mid-FETCH or mid-MEM SHALL drop imem_req/dmem_req in the same cycle, with no write or retire side effects.
REQ-040 After rst deasserts, the first fetch SHALL begin on the cycle after run is sampled high.

Structure
REQ-041 The state encoding, wb_sel codes, and trap_cause codes SHALL live in the shared package miniRV_ctrl_pkg.
REQ-042 The wait/timeout counter SHALL be a single sub-module, wait_timer, with clear, count, and expired ports.

Verification
REQ-043 Zero-wait memory, run=1, add: FETCH,DECODE,EXECUTE,WB over 4 cycles; one reg_write with wb_sel=0; retired 0->1.
REQ-044 lw with dmem_ready delayed 3 cycles: dmem_req high for 4 cycles; then WB with wb_sel=1; total 8 cycles.
REQ-045 sb with dmem_ready=1: dmem_we=1 and dmem_byte=1 for one cycle; pc_enable=1; reg_write never asserted.
REQ-046 illegal=1: trap=1, trap_cause=1 the cycle after DECODE; TRAP holds for 100 cycles with run=1; rst low clears it.
REQ-047 MEM_TIMEOUT=4 with imem_ready held low: TRAP with cause 2 after 4 wait cycles; with imem_ready rising on cycle 4, no trap occurs.
REQ-048 CNT_W=4 after 15 retired instructions: the next retirement wraps retired to 0; rst mid-MEM drops dmem_req asynchronously.
